// File: rtl/c5x7_pkg.sv
// Shared definitions for the c5x7 filter and its window generator:
// sample type, window geometry and the window index helper.
package c5x7_pkg;

   localparam int DW_SAMP = 40;
   localparam int N_ROWS  = 7;
   localparam int N_COLS  = 5;
   localparam int N_LB    = N_ROWS - 1;      // buffered previous rows
   localparam int N_WIN   = N_ROWS * N_COLS; // samples per window

   typedef logic signed [DW_SAMP-1:0] samp_t;

   // Flat window index of samp{r}{c}; matches the c5x7 sample numbering.
   function automatic int widx(input int r, input int c);
      return r * N_COLS + c;
   endfunction

endpackage

// File: rtl/c5x7_linebuf.sv
// Six-line sample store: one word per column holding lb0..lb5 packed
// with lb_k at [k*DW +: DW]. Single shared address, combinational
// read of the old word and a write of the new word on the same edge
// (read-before-write). Contents are never cleared; the window valid
// gate in the top level keeps stale lines from reaching the output.
module c5x7_linebuf
   import c5x7_pkg::*;
#(
   parameter int DW    = DW_SAMP,
   parameter int IMG_W = 64,
   parameter int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
)
(
   input  logic                clk,
   input  logic                wen,
   input  logic [AW-1:0]       addr,
   input  logic [N_LB*DW-1:0]  wdata,
   output logic [N_LB*DW-1:0]  rdata
);

   logic [N_LB*DW-1:0] mem_r [IMG_W];

   // Old word at the current column, visible before this edge's write.
   assign rdata = mem_r[addr];

   // Store the shifted column word on every accepted sample.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem_r[addr] <= wdata;
      end
   end

endmodule

// File: rtl/c5x7_window_gen.sv
// Raster-order to 7x5 window generator feeding c5x7. Tracks the
// raster position, buffers the six previous rows, shifts one new
// column into the window per accepted sample and flags windows whose
// newest sample sits at row >= 6, column >= 4. No backpressure.
module c5x7_window_gen
   import c5x7_pkg::*;
#(
   parameter int DW    = DW_SAMP,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_in,
   input  logic                   sof_in,
   input  logic signed [DW-1:0]   din,
   output logic                   pushout,
   output logic [N_WIN*DW-1:0]    win
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] COL_LAST        = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST        = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_FIRST_VALID = CW'(N_COLS - 1);
   localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(N_ROWS - 1);

   logic [CW-1:0]        col_cnt_r;
   logic [RW-1:0]        row_cnt_r;
   logic [CW-1:0]        col_cur_s;
   logic [RW-1:0]        row_cur_s;
   logic [CW-1:0]        col_nxt_s;
   logic [RW-1:0]        row_nxt_s;
   logic                 accept_s;
   logic                 valid_s;
   logic [N_LB*DW-1:0]   lb_rd_s;
   logic [N_LB*DW-1:0]   lb_wr_s;
   logic [N_ROWS*DW-1:0] newcol_s;
   logic [N_WIN*DW-1:0]  win_r;
   logic [N_WIN*DW-1:0]  win_nxt_s;
   logic                 pushout_r;

   // Position of the sample on din (sof forces 0,0), its successor, and window validity.
   always_comb begin
      col_cur_s = {CW{1'b0}};
      row_cur_s = {RW{1'b0}};
      col_nxt_s = {CW{1'b0}};
      row_nxt_s = {RW{1'b0}};
      accept_s  = push_in & reset;
      if (sof_in) begin
         col_cur_s = {CW{1'b0}};
         row_cur_s = {RW{1'b0}};
      end else begin
         col_cur_s = col_cnt_r;
         row_cur_s = row_cnt_r;
      end
      if (col_cur_s == COL_LAST) begin
         col_nxt_s = {CW{1'b0}};
         if (row_cur_s == ROW_LAST) begin
            row_nxt_s = {RW{1'b0}};
         end else begin
            row_nxt_s = row_cur_s + RW'(1);
         end
      end else begin
         col_nxt_s = col_cur_s + CW'(1);
         row_nxt_s = row_cur_s;
      end
      valid_s = accept_s & (row_cur_s >= ROW_FIRST_VALID) & (col_cur_s >= COL_FIRST_VALID);
   end

   // Raster position counters advance only on accepted samples.
   always_ff @(posedge clk) begin
      if (!reset) begin
         col_cnt_r <= {CW{1'b0}};
         row_cnt_r <= {RW{1'b0}};
      end else if (accept_s) begin
         col_cnt_r <= col_nxt_s;
         row_cnt_r <= row_nxt_s;
      end else begin
         col_cnt_r <= col_cnt_r;
         row_cnt_r <= row_cnt_r;
      end
   end

   c5x7_linebuf #(
      .DW    (DW),
      .IMG_W (IMG_W),
      .AW    (CW)
   ) u_linebuf (
      .clk   (clk),
      .wen   (accept_s),
      .addr  (col_cur_s),
      .wdata (lb_wr_s),
      .rdata (lb_rd_s)
   );

   // New column (oldest row at row 0, din at row 6), line-buffer update word and shifted window.
   always_comb begin
      newcol_s  = {din, lb_rd_s};
      lb_wr_s   = {din, lb_rd_s[N_LB*DW-1:DW]};
      win_nxt_s = win_r;
      for (int r = 0; r < N_ROWS; r++) begin
         for (int c = 0; c < N_COLS - 1; c++) begin
            win_nxt_s[widx(r, c)*DW +: DW] = win_r[widx(r, c + 1)*DW +: DW];
         end
         win_nxt_s[widx(r, N_COLS - 1)*DW +: DW] = newcol_s[r*DW +: DW];
      end
   end

   // Window array shifts on accept and holds otherwise; pushout marks a completed window.
   always_ff @(posedge clk) begin
      if (!reset) begin
         win_r     <= {(N_WIN*DW){1'b0}};
         pushout_r <= 1'b0;
      end else begin
         pushout_r <= valid_s;
         if (accept_s) begin
            win_r <= win_nxt_s;
         end else begin
            win_r <= win_r;
         end
      end
   end

   assign pushout = pushout_r;
   assign win     = win_r;

endmodule

// File: doc/c5x7_window_gen.md
# c5x7_window_gen

Window generator sitting directly upstream of `c5x7`. It accepts a raster-order stream of signed 40-bit samples, buffers the six previous image rows, and emits a complete 7-row × 5-column window with a single-cycle push. The window drives `c5x7`'s `samp00..samp64` inputs and `push_samp` with no backpressure. Valid-only windows are produced; no edge padding.

## Interface
- `DW`, 40, sample width (signed)
- `IMG_W`, 64, samples per row (≥5)
- `IMG_H`, 64, rows per frame (≥7)

- `clk` in 1 rising-edge clock
- `reset` in 1 reset, synchronous, active-low
- `push_in` in 1 input sample valid; accepted every cycle it is high
- `sof_in` in 1 start of frame; qualified by `push_in`
- `din` in DW signed sample
- `pushout` out 1 window valid, one-cycle pulse per window; drives `push_samp`
- `win` out 35*DW; `samp{r}{c}` is at `[(r*5+c)*DW +: DW]`, index 0..34 matches `c5x7` sample numbering

## Operation
- Row 6 holds the newest row and row 0 the oldest. Column 4 holds the newest column. `samp64` is the most recently accepted sample.
- Counters:
  - `col_cnt` runs 0..IMG_W-1; `row_cnt` runs 0..IMG_H-1.
  - Each accepted sample increments `col_cnt`. At IMG_W-1, `col_cnt` wraps to 0 and `row_cnt` increments.
  - At (IMG_H-1, IMG_W-1) both counters wrap to 0, so back-to-back frames need no `sof_in`.
- `sof_in` with `push_in`: the sample is taken as (row 0, col 0) whatever the counter state. `sof_in` without `push_in` is ignored.
- Line buffers: 6 lines × IMG_W × DW, indexed by `col_cnt`. On accept at column c:
  - newcol = {lb0[c], lb1[c], …, lb5[c], din} for rows 0..6.
  - Then lb_k[c] ← lb_{k+1}[c] for k = 0..4, and lb5[c] ← din.
  - Read happens before write within the same cycle.
- Window shift on accept: for each row r, win[r][0..3] ← win[r][1..4] and win[r][4] ← newcol[r]. Without an accept, the window holds.
- A window is valid when the accepted sample has `row_cnt` ≥ 6 and `col_cnt` ≥ 4. This gives (IMG_W-4)·(IMG_H-6) windows per frame.
- Arithmetic: pure data movement. Sign is preserved bit-exact and there is no width change.
- Line buffers are not cleared by reset or `sof_in`. Stale data cannot reach a valid window because of the `row_cnt` ≥ 6 gate.

## Timing
- Latency: `pushout` and the updated `win` appear one cycle after the edge that accepts the completing sample. All outputs are registered and stable for the full cycle.
- Throughput: one sample per cycle sustained. `pushout` may be high on consecutive cycles within a row.
- Gaps in `push_in` stall everything. `pushout` is 0 during gap cycles and `win` holds.
- Reset values: `pushout` = 0, `win` = 0, `col_cnt` = 0, `row_cnt` = 0.
- Reset asserted mid-frame: state clears at the next edge and `push_in` is ignored while `reset` = 0. The first sample after reset is treated as (0,0).
- Simultaneous `sof_in` and a completing position: `sof_in` wins, the sample is treated as (0,0), and `pushout` = 0.
- Frame wrap and row wrap in the same cycle are handled by the counter rules above; no extra cycle is inserted.

## Structure
- Package `c5x7_pkg`:
  - `DW_SAMP` = 40
  - `N_ROWS` = 7, `N_COLS` = 5
  - `typedef logic signed [DW_SAMP-1:0] samp_t`
  - window index function `widx(r,c) = r*5+c`
  - `c5x7` reuses the same package.
- Sub-module `c5x7_linebuf`: IMG_W × (6·DW) storage, one read and one write port on the same address in the same cycle, read-before-write. It is replaceable by an SRAM macro.
- Top level holds the counters, the valid logic, and the 7×5 window register array.

## Test plan
- **Ramp:** IMG_W=8, IMG_H=8, `din` = r·8+c, `push_in` every cycle.
  - First `pushout` one cycle after sample 52 is accepted, with `samp00`=0, `samp04`=4, `samp34`=28, `samp64`=52.
  - Exactly 8 pulses per frame. Last window has `samp64`=63 and `samp00`=11.
- **Signedness:** IMG_W=8, IMG_H=8, `din` = −(r·8+c)−1 (40-bit two's complement). The first window has `samp00` = 40'hFF_FFFF_FFFF and `samp64` = −53, bit-exact.
- **Gaps:** the ramp test with `push_in` deasserted for a random 0–3 cycles between samples produces identical window contents and count. `pushout` is never high during a gap.
- **Back-to-back frames:** two ramp frames with no `sof_in`. The second frame's first `pushout` follows accepted sample 116, with `samp00` = 0 and `samp64` = 52 of frame 2. There is no pulse at the frame boundary.
- **sof mid-frame:**
  - Send a ramp frame through row 3, then `sof_in` with a new ramp: no pulse until new-frame sample 52.
  - Send a ramp frame through row 7, then `sof_in` with a new ramp: the first window equals a clean-frame first window.
- **Reset mid-frame:** drive `reset`=0 for 2 cycles during row 6. `pushout`=0 and `win`=0 one edge later. Restarting a ramp gives a first `pushout` after sample 52.
